// File: rtl/instr_encoder_loader.sv
// Packs decoded R-type fields into RV32I words and writes them to consecutive
// instruction-memory addresses. Optional macro RTYPE_CHECK_EN rejects non-R-type sets.
module instr_encoder_loader #(
  parameter int unsigned ADDR_W = 8,
  parameter int unsigned DEPTH  = 256
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              stop,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [6:0]        opcode,
  input  logic [4:0]        rs1,
  input  logic [4:0]        rs2,
  input  logic [4:0]        rd,
  input  logic [2:0]        funct3,
  input  logic [6:0]        funct7,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic [ADDR_W:0]   count,
  output logic              full,
  output logic              error
);

  localparam int unsigned CNT_W = ADDR_W + 1;
  localparam logic [CNT_W-1:0] DEPTH_CNT = CNT_W'(DEPTH);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    FULL = 2'd2
  } state_t;

  state_t            state;
  logic [ADDR_W-1:0] wr_ptr;
  logic              xfer;
  logic              legal;
  logic              commit;
  logic [31:0]       word;
  logic [CNT_W-1:0]  count_inc;

  assign xfer      = in_valid & in_ready;
  assign word      = {funct7, rs2, rs1, funct3, rd, opcode};
  assign count_inc = count + CNT_W'(1);
  assign commit    = xfer & legal;

`ifdef RTYPE_CHECK_EN
  assign legal = (opcode == 7'b0110011) && ((funct7 == 7'h00) || (funct7 == 7'h20));

  // Sticky until the next start or reset; a dropped start-cycle transfer does not count.
  always_ff @(posedge clk) begin
    if (rst) begin
      error <= 1'b0;
    end else if (start) begin
      error <= 1'b0;
    end else if (xfer && !legal) begin
      error <= 1'b1;
    end
  end
`else
  assign legal = 1'b1;
  assign error = 1'b0;
`endif

  // Pointer, count and write stage all advance on the accepting edge, so count
  // and full become visible in the same cycle as mem_we.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      in_ready  <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      wr_ptr    <= '0;
      count     <= '0;
      full      <= 1'b0;
    end else begin
      mem_we <= 1'b0;
      if (start) begin
        state    <= LOAD;
        in_ready <= 1'b1;
        wr_ptr   <= '0;
        count    <= '0;
        full     <= 1'b0;
      end else begin
        if (commit) begin
          mem_we    <= 1'b1;
          mem_addr  <= wr_ptr;
          mem_wdata <= word;
          wr_ptr    <= wr_ptr + ADDR_W'(1);
          count     <= count_inc;
          full      <= (count_inc == DEPTH_CNT);
        end
        case (state)
          IDLE: begin
            in_ready <= 1'b0;
          end
          LOAD: begin
            if (stop) begin
              state    <= IDLE;
              in_ready <= 1'b0;
            end else if (commit && (count_inc == DEPTH_CNT)) begin
              state    <= FULL;
              in_ready <= 1'b0;
            end else begin
              in_ready <= 1'b1;
            end
          end
          FULL: begin
            in_ready <= 1'b0;
            if (stop) begin
              state <= IDLE;
            end
          end
          default: begin
            state    <= IDLE;
            in_ready <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule
